spike_encoder: RTL and testbench

Rate-coding spike source that turns eight per-channel intensity values into spike trains. The 8-bit spike vector drives the 8-input neuron from the transmit side. A host loads intensities over a valid/ready port. The block advances one timestep every TICK_DIV clocks and emits that timestep's spikes from a 32-bit LFSR compared against each intensity. It sits between the top-level input pins or host logic and the neuron's spike inputs.

---
 rtl/spike_pkg.sv | 11 +
 rtl/lfsr32.sv | 30 +++
 rtl/spike_encoder.sv | 125 ++++++++++++
 tb/tb_spike_encoder.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spike_pkg.sv
// Shared constants and types for the rate-coding spike encoder.
package spike_pkg;

    localparam int          NUM_CH        = 8;
    localparam int          VAL_W         = 4;
    localparam logic [31:0] LFSR_POLY     = 32'h8020_0003;
    localparam logic [31:0] LFSR_SEED_DEF = 32'hACE1_2468;

    typedef logic [VAL_W-1:0] val_t;

endpackage

// File: rtl/lfsr32.sv
// 32-bit right-shifting Galois LFSR; free-running once out of reset.
module lfsr32
    import spike_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] seed,
    output logic [31:0] q
);

    logic [31:0] lfsr_q;
    logic [31:0] lfsr_d;

    // next state: shift right, fold the polynomial in when bit 0 falls out
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'h0);
    end

    // state register, loads the seed during reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/spike_encoder.sv
// Rate-coding spike source: eight intensities in, one spike vector per timestep out.
// Build option: SPIKE_ENC_DETERMINISTIC_EN replaces the LFSR with per-channel
// phase accumulators that give an exact, evenly spaced val/16 spike rate.
module spike_encoder
    import spike_pkg::*;
#(
    parameter logic [23:0] TICK_DIV  = 24'd10_000,
    parameter logic [31:0] LFSR_SEED = LFSR_SEED_DEF
)
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [2:0]        ld_ch,
    input  logic [VAL_W-1:0]  ld_val,
    output logic [NUM_CH-1:0] spikes,
    output logic              tick_o
);

    logic [23:0]       cnt_q,    cnt_d;
    logic              rdy_q,    rdy_d;
    val_t              val_q    [NUM_CH];
    val_t              val_d    [NUM_CH];
    logic [NUM_CH-1:0] spikes_q, spikes_d;
    logic              tick_q,   tick_d;
    logic              tick;

    // tick decoded straight from the counter; writes are refused in that cycle
    assign tick     = en && (cnt_q == (TICK_DIV - 24'd1));
    assign ld_ready = rdy_q && !tick;

    // timestep counter, write port, and the ready-after-reset flag
    always_comb begin
        cnt_d = cnt_q + 24'd1;
        if (!en || tick) begin
            cnt_d = '0;
        end
        rdy_d = 1'b1;
        val_d = val_q;
        if (ld_valid && ld_ready) begin
            val_d[ld_ch] = ld_val;
        end
        tick_d = tick;
    end

`ifdef SPIKE_ENC_DETERMINISTIC_EN
    val_t       acc_q   [NUM_CH];
    val_t       acc_d   [NUM_CH];
    logic [VAL_W:0] acc_sum [NUM_CH];

    // accumulator step; the carry out of each channel is its spike
    always_comb begin
        spikes_d = spikes_q;
        acc_d    = acc_q;
        for (int i = 0; i < NUM_CH; i++) begin
            acc_sum[i] = {1'b0, acc_q[i]} + {1'b0, val_q[i]};
        end
        if (tick) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_d[i]    = acc_sum[i][VAL_W-1:0];
                spikes_d[i] = acc_sum[i][VAL_W];
            end
        end else if (!en) begin
            spikes_d = '0;
        end
    end

    // accumulator registers, held while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            acc_q <= acc_d;
        end
    end
`else
    logic [31:0] lfsr;

    lfsr32 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .seed  (LFSR_SEED),
        .q     (lfsr)
    );

    // stochastic coding: spike when this channel's LFSR nibble is below its intensity
    always_comb begin
        spikes_d = spikes_q;
        if (tick) begin
            for (int i = 0; i < NUM_CH; i++) begin
                spikes_d[i] = (lfsr[VAL_W*i +: VAL_W] < val_q[i]);
            end
        end else if (!en) begin
            spikes_d = '0;
        end
    end
`endif

    // all encoder state, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            rdy_q    <= 1'b0;
            spikes_q <= '0;
            tick_q   <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                val_q[i] <= '0;
            end
        end else begin
            cnt_q    <= cnt_d;
            rdy_q    <= rdy_d;
            spikes_q <= spikes_d;
            tick_q   <= tick_d;
            val_q    <= val_d;
        end
    end

    assign spikes = spikes_q;
    assign tick_o = tick_q;

endmodule

// File: tb/tb_spike_encoder.sv
// Self-checking bench for spike_encoder (TICK_DIV = 4, default seed).
module tb_spike_encoder;
    import spike_pkg::*;

    localparam logic [23:0] TD   = 24'd4;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [2:0] ld_ch = '0;
    logic [3:0] ld_val = '0;
    logic [7:0] spikes;
    logic       tick_o;

    always #5 clk = ~clk;

    spike_encoder #(.TICK_DIV(TD), .LFSR_SEED(SEED)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .ld_valid (ld_valid),
        .ld_ready (ld_ready),
        .ld_ch    (ld_ch),
        .ld_val   (ld_val),
        .spikes   (spikes),
        .tick_o   (tick_o)
    );

    int n_pass = 0;
    int n_chk  = 0;

    // reference model state (behavioural, integer counters)
    logic [31:0] m_lfsr;
    int          m_cnt;
    bit          m_rdy;
    int          m_val [8];
    int          m_acc [8];
    logic [7:0]  m_spk;
    bit          m_tick_o;
    bit          act_ready;
    bit          act_tick;
    bit          accepted;

    typedef struct {
        bit         en;
        bit         v;
        logic [2:0] ch;
        logic [3:0] val;
        bit         x_ready;
        bit         x_tick;
    } vec_t;

    vec_t tbl [13];

    function automatic logic [31:0] next_lfsr(input logic [31:0] x);
        return (x >> 1) ^ (x[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_lfsr   = SEED;
        m_cnt    = 0;
        m_rdy    = 1'b0;
        m_spk    = '0;
        m_tick_o = 1'b0;
        for (int i = 0; i < 8; i++) begin
            m_val[i] = 0;
            m_acc[i] = 0;
        end
    endtask

    // one clock: drive, check ready before the edge, advance model, check outputs after
    task automatic step(input bit e, input bit v, input logic [2:0] ch, input logic [3:0] val);
        bit m_tick;
        bit m_ready;
        int sum;
        logic [31:0] nib;
        en = e; ld_valid = v; ld_ch = ch; ld_val = val;
        #1;
        m_tick  = e && (m_cnt == int'(TD) - 1);
        m_ready = m_rdy && !m_tick;
        act_ready = ld_ready;
        chk("ld_ready", {31'b0, ld_ready}, {31'b0, m_ready});
        @(posedge clk);
        if (m_tick) begin
            for (int i = 0; i < 8; i++) begin
`ifdef SPIKE_ENC_DETERMINISTIC_EN
                sum = m_acc[i] + m_val[i];
                m_spk[i] = (sum >= 16);
                m_acc[i] = sum % 16;
`else
                nib = (m_lfsr >> (4 * i)) & 32'hF;
                m_spk[i] = (int'(nib) < m_val[i]);
`endif
            end
        end else if (!e) begin
            m_spk = '0;
        end
        m_tick_o = m_tick;
        if (v && m_ready) m_val[ch] = int'(val);
        m_lfsr = next_lfsr(m_lfsr);
        m_cnt  = (e && !m_tick) ? m_cnt + 1 : 0;
        m_rdy  = 1'b1;
        #1;
        act_tick = tick_o;
        chk("spikes", {24'b0, spikes}, {24'b0, m_spk});
        chk("tick_o", {31'b0, tick_o}, {31'b0, m_tick_o});
        accepted = v && act_ready;
    endtask

    task automatic write_val(input logic [2:0] ch, input logic [3:0] val);
        int tries = 0;
        accepted = 1'b0;
        while (!accepted && tries < 4) begin
            step(1'b1, 1'b1, ch, val);
            tries++;
        end
        chk("write_accept", {31'b0, accepted}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int ticks, cnt1, viol0, guard, zero_viol;
        bit ok;

        // per-cycle vectors from cnt = 0: ticks before edges 4, 8, 12; write collides at 4
        tbl[0]  = '{1'b1, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 3'd2, 4'd9, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 3'd2, 4'd9, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 3'd0, 4'd0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b0, 3'd0, 4'd0, 1'b1, 1'b0};

        // reset held for 3 cycles
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_spikes", {24'b0, spikes}, 32'd0);
        chk("rst_tick", {31'b0, tick_o}, 32'd0);
        chk("rst_ready", {31'b0, ld_ready}, 32'd0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 3'd0, 4'd0);

`ifdef SPIKE_ENC_DETERMINISTIC_EN
        write_val(3'd3, 4'd4);
        step(1'b0, 1'b0, 3'd0, 4'd0);
        ticks = 0; cnt1 = 0; guard = 0;
        while (ticks < 16 && guard < 100) begin
            step(1'b1, 1'b0, 3'd0, 4'd0);
            guard++;
            if (act_tick) begin
                ticks++;
                if (spikes[3]) cnt1 |= (1 << (ticks - 1));
            end
        end
        chk("det_ticks", ticks, 16);
        chk("det_pattern", cnt1, 32'h0000_8888);
        rst_n = 1'b0;
        #1;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        step(1'b0, 1'b0, 3'd0, 4'd0);
`endif

        // tick cadence and write/tick collision
        for (int j = 0; j < 13; j++) begin
            step(tbl[j].en, tbl[j].v, tbl[j].ch, tbl[j].val);
            chk($sformatf("vec%0d_ready", j), {31'b0, act_ready}, {31'b0, tbl[j].x_ready});
            chk($sformatf("vec%0d_tick", j), {31'b0, act_tick}, {31'b0, tbl[j].x_tick});
        end
        chk("collision_model_val", m_val[2], 9);

        // extremes: val[0] = 0, val[1] = 15 over 1000 ticks
        write_val(3'd1, 4'd15);
        ticks = 0; cnt1 = 0; viol0 = 0; guard = 0;
        while (ticks < 1000 && guard < 4100) begin
            step(1'b1, 1'b0, 3'd0, 4'd0);
            guard++;
            if (spikes[0]) viol0++;
            if (act_tick) begin
                ticks++;
                if (spikes[1]) cnt1++;
            end
        end
        chk("ext_ticks", ticks, 1000);
        chk("ext_ch0_zero", viol0, 0);
        ok = (cnt1 >= 900) && (cnt1 <= 975);
        chk("ext_ch1_range", {31'b0, ok}, 32'd1);

        // en drop mid-timestep with every channel saturated
        for (int c = 0; c < 8; c++) write_val(3'(c), 4'd15);
        guard = 0;
        act_tick = 1'b0;
        while (!act_tick && guard < 8) begin
            step(1'b1, 1'b0, 3'd0, 4'd0);
            guard++;
        end
        chk("drop_sync", {31'b0, act_tick}, 32'd1);
        step(1'b1, 1'b0, 3'd0, 4'd0);
        step(1'b1, 1'b0, 3'd0, 4'd0);
        step(1'b0, 1'b0, 3'd0, 4'd0);
        chk("drop_spikes_zero", {24'b0, spikes}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            step(1'b1, 1'b0, 3'd0, 4'd0);
            chk($sformatf("restart_tick%0d", k), {31'b0, act_tick}, (k == 4) ? 32'd1 : 32'd0);
        end

        // randomized traffic against the model
        for (int k = 0; k < 2000; k++) begin
            step(($urandom_range(0, 19) != 0), ($urandom_range(0, 2) == 0),
                 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
        end

        // reset asserted mid-timestep clears everything including intensities
        step(1'b1, 1'b0, 3'd0, 4'd0);
        rst_n = 1'b0;
        #1;
        chk("midrst_spikes", {24'b0, spikes}, 32'd0);
        chk("midrst_tick", {31'b0, tick_o}, 32'd0);
        chk("midrst_ready", {31'b0, ld_ready}, 32'd0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        zero_viol = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b1, 1'b0, 3'd0, 4'd0);
            if (spikes != 8'h00) zero_viol++;
        end
        chk("midrst_vals_cleared", zero_viol, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
